// File: rtl/ram_loader_pkg.sv
// Shared command codes, FSM state encoding and length convention for ram_loader.
package ram_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  localparam int unsigned LEN_ZERO_MEANS = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    LEN     = 3'd3,
    WDATA   = 3'd4,
    RADDR   = 3'd5,
    RWAIT   = 3'd6,
    RSEND   = 3'd7
  } state_t;

endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream, transmit handshake and RAM pin bundle between ram_loader and its neighbours.
interface ram_loader_if #(
  parameter int unsigned A = 10
) ();

  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [A-1:0] ram_addr;
  logic [7:0]   ram_din;
  logic         ram_we;
  logic [7:0]   ram_dout;
  logic         busy;
  logic         err;

  modport master (
    input  rx_data, rx_valid, tx_ready, ram_dout,
    output tx_data, tx_valid, ram_addr, ram_din, ram_we, busy, err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, ram_dout,
    input  tx_data, tx_valid, ram_addr, ram_din, ram_we, busy, err
  );

endinterface

// File: rtl/ram_loader.sv
// Byte-stream write-block / read-block command engine driving a synchronous RAM.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned A = 10
) (
  input  logic         clk,
  input  logic         rst,
  ram_loader_if.master bus
);

  state_t       state, state_n;
  logic         is_write, is_write_n;
  logic [7:0]   addr_hi, addr_hi_n;
  logic [A-1:0] addr, addr_n;
  logic [8:0]   count, count_n;

  logic [7:0]   tx_data_n;
  logic         tx_valid_n;
  logic [A-1:0] ram_addr_n;
  logic [7:0]   ram_din_n;
  logic         ram_we_n;
  logic         err_n;

  always_comb begin
    state_n    = state;
    is_write_n = is_write;
    addr_hi_n  = addr_hi;
    addr_n     = addr;
    count_n    = count;
    tx_data_n  = bus.tx_data;
    tx_valid_n = bus.tx_valid;
    ram_addr_n = bus.ram_addr;
    ram_din_n  = bus.ram_din;
    ram_we_n   = 1'b0;
    err_n      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
            is_write_n = (bus.rx_data == CMD_WRITE);
            state_n    = ADDR_HI;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ADDR_HI: begin
        if (bus.rx_valid) begin
          addr_hi_n = bus.rx_data;
          state_n   = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (bus.rx_valid) begin
          addr_n  = A'({addr_hi, bus.rx_data});
          state_n = LEN;
        end
      end
      LEN: begin
        if (bus.rx_valid) begin
          count_n = (bus.rx_data == 8'd0) ? 9'(LEN_ZERO_MEANS) : {1'b0, bus.rx_data};
          state_n = is_write ? WDATA : RADDR;
        end
      end
      WDATA: begin
        if (bus.rx_valid) begin
          ram_we_n   = 1'b1;
          ram_din_n  = bus.rx_data;
          ram_addr_n = addr;
          addr_n     = addr + 1'b1;
          count_n    = count - 9'd1;
          if (count == 9'd1) state_n = IDLE;
        end
      end
      RADDR: state_n = RWAIT;
      RWAIT: begin
        tx_data_n  = bus.ram_dout;
        tx_valid_n = 1'b1;
        state_n    = RSEND;
      end
      RSEND: begin
        if (bus.tx_ready) begin
          tx_valid_n = 1'b0;
          addr_n     = addr + 1'b1;
          count_n    = count - 9'd1;
          state_n    = (count == 9'd1) ? IDLE : RADDR;
        end
      end
      default: state_n = IDLE;
    endcase

    // Register the read address on entry to RADDR so the RAM sees it during
    // RADDR and ram_dout is already valid while in RWAIT.
    if (state_n == RADDR) ram_addr_n = addr_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      is_write     <= 1'b0;
      addr_hi      <= '0;
      addr         <= '0;
      count        <= '0;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
      bus.ram_we   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      state        <= state_n;
      is_write     <= is_write_n;
      addr_hi      <= addr_hi_n;
      addr         <= addr_n;
      count        <= count_n;
      bus.tx_data  <= tx_data_n;
      bus.tx_valid <= tx_valid_n;
      bus.ram_addr <= ram_addr_n;
      bus.ram_din  <= ram_din_n;
      bus.ram_we   <= ram_we_n;
      bus.busy     <= (state_n != IDLE);
      bus.err      <= err_n;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader with a behavioural synchronous RAM attached.
module tb_ram_loader;
  import ram_loader_pkg::*;

  localparam int unsigned A     = 10;
  localparam int unsigned DEPTH = 1 << A;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_loader_if #(.A(A)) bus ();
  ram_loader #(.A(A)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem     [DEPTH];
  logic [7:0] exp_mem [DEPTH];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  typedef struct packed {
    logic [A-1:0] addr;
    logic [7:0]   data;
  } wr_t;

  wr_t        wq [$];
  logic [7:0] rq [$];
  logic [7:0] wbuf [256];

  int checks = 0;
  int fails  = 0;
  int we_seen  = 0;
  int err_seen = 0;

  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) we_seen++;
    if (bus.err === 1'b1) err_seen++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  // Sends a write command of n bytes from wbuf but only the first nsend data bytes.
  task automatic send_write(input logic [15:0] a, input int n, input int nsend);
    int   base;
    wr_t  w;
    logic [A-1:0] ea;
    logic [7:0] lb;
    base = we_seen;
    lb = (n == 256) ? 8'h00 : n[7:0];
    send_byte(CMD_WRITE);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(lb);
    for (int i = 0; i < nsend; i++) begin
      ea = a[A-1:0] + A'(i);
      w.addr = ea;
      w.data = wbuf[i];
      wq.push_back(w);
      exp_mem[ea] = wbuf[i];
      send_byte(wbuf[i]);
      @(negedge clk);
      w = wq.pop_front();
      checks++;
      if (bus.ram_we !== 1'b1 || bus.ram_addr !== w.addr || bus.ram_din !== w.data) begin
        fails++;
        $display("FAIL wr_byte%0d: we=%b addr=%h din=%h, required we=1 addr=%h din=%h",
                 i, bus.ram_we, bus.ram_addr, bus.ram_din, w.addr, w.data);
      end
    end
    checks++;
    if (bus.busy !== ((nsend < n) ? 1'b1 : 1'b0)) begin
      fails++;
      $display("FAIL wr_busy: busy=%b after %0d of %0d bytes", bus.busy, nsend, n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (we_seen - base != nsend) begin
      fails++;
      $display("FAIL wr_we_count: %0d ram_we cycles, required %0d", we_seen - base, nsend);
    end
  endtask

  task automatic read_stream(input logic [15:0] a, input int n, input int stall, input bit inject);
    int eb, wb, t;
    bit stable;
    logic [7:0] d, e;
    logic [7:0] lb;
    eb = err_seen;
    wb = we_seen;
    for (int i = 0; i < n; i++) rq.push_back(exp_mem[a[A-1:0] + A'(i)]);
    lb = (n == 256) ? 8'h00 : n[7:0];
    send_byte(CMD_READ);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(lb);
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      while (bus.tx_valid !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (bus.tx_valid !== 1'b1) begin
        fails++;
        $display("FAIL rd_timeout: byte %0d tx_valid=%b, required 1 within 20 cycles", i, bus.tx_valid);
        rq.delete();
        return;
      end
      d = bus.tx_data;
      stable = 1'b1;
      for (int s = 0; s < stall; s++) begin
        if (inject) begin
          bus.rx_valid = (s == 0 || s == 2);
          bus.rx_data  = (s == 0) ? 8'h41 : CMD_WRITE;
        end
        @(negedge clk);
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== d) stable = 1'b0;
      end
      bus.rx_valid = 1'b0;
      if (stall > 0) begin
        checks++;
        if (!stable) begin
          fails++;
          $display("FAIL rd_stable: byte %0d tx_valid=%b tx_data=%h, required held 1/%h",
                   i, bus.tx_valid, bus.tx_data, d);
        end
      end
      bus.tx_ready = 1'b1;
      @(posedge clk);
      #1 bus.tx_ready = 1'b0;
      e = rq.pop_front();
      checks++;
      if (d !== e) begin
        fails++;
        $display("FAIL rd_data: byte %0d got %h, required %h", i, d, e);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_end: busy=%b tx_valid=%b, required 0/0", bus.busy, bus.tx_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_seen != eb || we_seen != wb) begin
      fails++;
      $display("FAIL rd_side: err cycles %0d we cycles %0d, required 0/0", err_seen - eb, we_seen - wb);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.tx_data !== 8'h00 || bus.tx_valid !== 1'b0 || bus.ram_addr !== '0 ||
        bus.ram_din !== 8'h00 || bus.ram_we !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL %s: tx_data=%h tx_valid=%b ram_addr=%h ram_din=%h we=%b busy=%b err=%b, required all 0",
               name, bus.tx_data, bus.tx_valid, bus.ram_addr, bus.ram_din, bus.ram_we, bus.busy, bus.err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_values");
    rst = 1'b0;
  endtask

  task automatic test_write;
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
    send_write(16'h0010, 3, 3);
  endtask

  task automatic test_read_backpressure;
    read_stream(16'h0010, 3, 5, 1'b0);
  endtask

  task automatic test_wrap_len0;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    send_write(16'h03FF, 2, 2);
    read_stream(16'h0000, 256, 0, 1'b0);
  endtask

  task automatic test_unknown_cmd;
    int eb;
    eb = err_seen;
    send_byte(8'h41);
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL unk_err: err=%b busy=%b, required 1/0", bus.err, bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_seen - eb != 1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL unk_pulse: err cycles %0d busy=%b, required 1/0", err_seen - eb, bus.busy);
    end
    read_stream(16'h0011, 1, 0, 1'b0);
  endtask

  task automatic test_ignored_rx;
    read_stream(16'h0010, 3, 5, 1'b1);
  endtask

  task automatic test_reset_mid;
    wbuf[0] = 8'h5C; wbuf[1] = 8'hC5;
    send_write(16'h0100, 5, 2);
    @(negedge clk);
    rst = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = CMD_WRITE;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_release");
    wbuf[0] = 8'h33;
    send_write(16'h0020, 1, 1);
    read_stream(16'h0100, 3, 1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     <= 8'(i) ^ 8'h5A;
      exp_mem[i]  = 8'(i) ^ 8'h5A;
    end
    rst          = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    test_reset;
    test_write;
    test_read_backpressure;
    test_wrap_len0;
    test_unknown_cmd;
    test_ignored_rx;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Byte-stream command engine that sits directly upstream of the synchronous RAM and drives its addr/din/we pins.
- Receives bytes from the UART receiver. Executes write-block and read-block commands against the RAM.
- Returns read data as a byte stream with valid/ready handshake toward the UART transmitter.
- Used to load programs and dump memory on the icestick 8-bit design.

Parameters:
A, 10, RAM address width in bits; RAM depth is 1<<A bytes. Data width is fixed at 8.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe, rx_data valid; no backpressure
tx_data  output  8  byte to transmit
tx_valid  output  1  tx_data valid, held until accepted
tx_ready  input  1  transmitter accepts byte when tx_valid&&tx_ready
ram_addr  output  A  RAM address
ram_din  output  8  RAM write data
ram_we  output  1  RAM write enable, one-cycle pulse per byte
ram_dout  input  8  RAM read data, valid 1 cycle after ram_addr (sync RAM)
busy  output  1  high whenever state != IDLE
err  output  1  one-cycle pulse on unknown command byte

Behaviour:
- One clock; reset is synchronous and active-high. Reset wins over all other inputs in the same cycle.
- All outputs are registered. Reset values:
  - tx_data=0, tx_valid=0
  - ram_addr=0, ram_din=0, ram_we=0
  - busy=0, err=0
  - state=IDLE, byte counter=0
- Protocol:
  - Write: cmd, addr_hi, addr_lo, len, then len data bytes. CMD_WRITE=0x57 ('W').
  - Read: cmd, addr_hi, addr_lo, len. CMD_READ=0x52 ('R').
  - Address is {addr_hi,addr_lo}[A-1:0]; upper bits are ignored.
  - len=0 means 256 bytes.
- States: IDLE, ADDR_HI, ADDR_LO, LEN, WDATA, RADDR, RWAIT, RSEND. Every transition below on an rx byte happens only on rx_valid.
- IDLE:
  - On 0x57 or 0x52, latch command and go to ADDR_HI.
  - On any other byte, pulse err for 1 cycle and stay in IDLE.
- ADDR_HI: latch the byte, then go to ADDR_LO.
- ADDR_LO: latch the byte, then go to LEN.
- LEN: latch count (0 maps to 256; the counter is 9 bits).
  - Write: go to WDATA.
  - Read: go to RADDR.
- WDATA, per rx byte:
  - In the next cycle: ram_we=1, ram_din=byte, ram_addr=current address.
  - Then increment the address and decrement the counter.
  - After the write for the last byte, return to IDLE.
  - Write latency is exactly 1 cycle from rx_valid to the ram_we pulse.
- RADDR: drive ram_addr=current address, ram_we=0, then go to RWAIT.
- RWAIT: capture ram_dout into tx_data, set tx_valid=1, go to RSEND.
- RSEND:
  - Hold tx_valid and tx_data stable until tx_ready.
  - On handshake, drop tx_valid, increment the address and decrement the counter.
  - If bytes remain, go to RADDR; otherwise go to IDLE.
- Read throughput: at most 1 byte per 3 cycles.
- Address wraps modulo 2^A. For A=10, 0x3FF is followed by 0x000.
- rx_valid during RADDR/RWAIT/RSEND is ignored: no state change, no err.
- ram_we is never high outside the cycle following a WDATA byte.
- Reset mid-command aborts immediately. There is no partial-write rollback: bytes already written stay in RAM.
- No timeout; an incomplete command waits indefinitely.

Decomposition:
- Shared package ram_loader_pkg holds:
  - CMD_WRITE=8'h57 and CMD_READ=8'h52
  - state enum (3-bit encoding)
  - LEN_ZERO_MEANS=256
- No sub-module is needed. ram_sync is instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold rst 2 cycles mid-write -> all outputs 0, busy=0, state IDLE; a following write command works normally.
- Write: rx 57,00,10,03,AA,BB,CC -> ram_we pulses at addrs 0x010,0x011,0x012 with din AA,BB,CC, each 1 cycle after its rx_valid; busy falls after the last write.
- Read with backpressure: preload 0x010..0x012=AA,BB,CC; rx 52,00,10,03; tx_ready low for 5 cycles per byte -> tx_data AA,BB,CC in order, tx_valid/tx_data stable while stalled, no duplicate or lost bytes.
- Wrap and len=0: rx 57,03,FF,02,11,22 -> writes 0x3FF=11, 0x000=22; rx 52,00,00,00 -> exactly 256 bytes returned.
- Unknown command: rx 41 -> err pulses 1 cycle, busy stays 0; following rx 52 is accepted as a command.
- Ignored rx during read: inject rx_valid bytes during RSEND -> output stream unchanged, no err, ram_we stays 0.
